// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined signed adder: op encoding,
// saturation bounds and signed-overflow detection.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Saturation bounds are built at this width and narrowed by the caller.
  localparam int unsigned MAX_W = 64;

  function automatic logic [MAX_W-1:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

  // sign_b is the sign of the original (un-inverted) B operand.
  function automatic logic ovf_detect(input logic op, input logic sign_a, input logic sign_b,
                                      input logic sign_r);
    logic same;
    same = (sign_a == sign_b);
    return ((op == OP_ADD) ? same : !same) && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/pipelined_signed_adder_if.sv
// Valid/ready operand and result bus for pipelined_signed_adder, plus the
// overflow counter clear and readback.
interface pipelined_signed_adder_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_0;
  logic [WIDTH-1:0] in_1;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] adder_out;
  logic             ovf;
  logic             cnt_clr;
  logic [CNT_W-1:0] ovf_cnt;

  modport master (
    output in_valid, in_0, in_1, sub, out_ready, cnt_clr,
    input  in_ready, out_valid, adder_out, ovf, ovf_cnt
  );

  modport slave (
    input  in_valid, in_0, in_1, sub, out_ready, cnt_clr,
    output in_ready, out_valid, adder_out, ovf, ovf_cnt
  );

endinterface

// File: rtl/pipe_stage.sv
// One pipeline register: W-bit payload plus valid bit, loaded when i_en is high,
// cleared by asynchronous active-low reset.
module pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipelined_signed_adder.sv
// Pipelined signed add/subtract with overflow flag and saturating overflow counter.
// Define ADDER_SAT_EN to clamp overflowing results instead of wrapping.
module pipelined_signed_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  pipelined_signed_adder_if.slave bus
);

  localparam int unsigned HalfW       = WIDTH / 2;
  localparam int unsigned ArithStages = (STAGES == 1) ? 1 : 2;
  localparam int unsigned ResW        = WIDTH + 1;

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_fin_valid;
  logic [WIDTH-1:0] w_fin_raw;
  logic             w_fin_ovf;
  logic [WIDTH-1:0] w_fin_res;
  logic [ResW-1:0]  w_chain_data  [ArithStages:STAGES];
  logic             w_chain_valid [ArithStages:STAGES];
  logic [CNT_W-1:0] r_ovf_cnt;

  // Whole pipeline stalls together whenever a held result is not taken.
  assign w_adv       = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;
  assign w_b_eff     = (bus.sub == OP_SUB) ? ~bus.in_1 : bus.in_1;

  if (STAGES == 1) begin : g_single
    assign w_fin_valid = bus.in_valid;
    assign w_fin_raw   = bus.in_0 + w_b_eff + {{(WIDTH-1){1'b0}}, bus.sub};
    assign w_fin_ovf   = ovf_detect(bus.sub, bus.in_0[WIDTH-1], bus.in_1[WIDTH-1],
                                    w_fin_raw[WIDTH-1]);
  end else begin : g_split
    localparam int unsigned S1W = 3 * HalfW + 2;
    logic [HalfW:0]   w_lo_sum;
    logic [S1W-1:0]   w_s1_d;
    logic [S1W-1:0]   w_s1_q;
    logic             w_carry_q;
    logic             w_sub_q;
    logic [HalfW-1:0] w_lo_q;
    logic [HalfW-1:0] w_a_hi_q;
    logic [HalfW-1:0] w_b_hi_q;
    logic [HalfW-1:0] w_hi_sum;

    assign w_lo_sum = {1'b0, bus.in_0[HalfW-1:0]} + {1'b0, w_b_eff[HalfW-1:0]}
                    + {{HalfW{1'b0}}, bus.sub};
    assign w_s1_d   = {w_lo_sum, bus.in_0[WIDTH-1:HalfW], w_b_eff[WIDTH-1:HalfW], bus.sub};

    pipe_stage #(.W(S1W)) u_s1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_adv),
      .i_valid (bus.in_valid),
      .i_data  (w_s1_d),
      .o_valid (w_fin_valid),
      .o_data  (w_s1_q)
    );

    assign {w_carry_q, w_lo_q, w_a_hi_q, w_b_hi_q, w_sub_q} = w_s1_q;
    assign w_hi_sum  = w_a_hi_q + w_b_hi_q + {{(HalfW-1){1'b0}}, w_carry_q};
    assign w_fin_raw = {w_hi_sum, w_lo_q};
    // Undo the subtract inversion to recover the original sign of B.
    assign w_fin_ovf = ovf_detect(w_sub_q, w_a_hi_q[HalfW-1], w_b_hi_q[HalfW-1] ^ w_sub_q,
                                  w_hi_sum[HalfW-1]);
  end

`ifdef ADDER_SAT_EN
  logic [WIDTH-1:0] w_sat_max;
  logic [WIDTH-1:0] w_sat_min;
  assign w_sat_max = WIDTH'(sat_max(WIDTH));
  assign w_sat_min = WIDTH'(sat_min(WIDTH));
  // On overflow the wrapped sign is the inverse of sign(A).
  assign w_fin_res = !w_fin_ovf ? w_fin_raw : (w_fin_raw[WIDTH-1] ? w_sat_max : w_sat_min);
`else
  assign w_fin_res = w_fin_raw;
`endif

  pipe_stage #(.W(ResW)) u_arith_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_adv),
    .i_valid (w_fin_valid),
    .i_data  ({w_fin_res, w_fin_ovf}),
    .o_valid (w_chain_valid[ArithStages]),
    .o_data  (w_chain_data[ArithStages])
  );

  for (genvar g = ArithStages + 1; g <= STAGES; g++) begin : g_delay
    pipe_stage #(.W(ResW)) u_dly (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_adv),
      .i_valid (w_chain_valid[g-1]),
      .i_data  (w_chain_data[g-1]),
      .o_valid (w_chain_valid[g]),
      .o_data  (w_chain_data[g])
    );
  end

  assign bus.out_valid            = w_chain_valid[STAGES];
  assign {bus.adder_out, bus.ovf} = w_chain_data[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_ovf_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready && bus.ovf && (r_ovf_cnt != '1)) begin
      r_ovf_cnt <= r_ovf_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.ovf_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_pipelined_signed_adder.sv
// Self-checking bench for pipelined_signed_adder (WIDTH=32, STAGES=2, CNT_W=4) using a
// 64-bit arithmetic reference model and a result scoreboard; honours ADDER_SAT_EN.
module tb_pipelined_signed_adder;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int          CntMax = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] wrap;
    logic [31:0] sat;
    logic        ovf;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  pipelined_signed_adder_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  pipelined_signed_adder #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int             checks    = 0;
  int             errors    = 0;
  int             n_out     = 0;
  int             model_cnt = 0;
  int             drv_stuck = 0;
  logic [WIDTH:0] exp_q[$];

  function automatic logic [WIDTH:0] ref_calc(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b, input logic s);
    longint           sa, sb, r, mx, mn;
    logic             o;
    logic [63:0]      ru;
    logic [WIDTH-1:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    mx = (longint'(1) <<< (WIDTH - 1)) - 1;
    mn = -mx - 1;
    r  = s ? sa - sb : sa + sb;
    o  = (r > mx) || (r < mn);
    ru = r;
    res = ru[WIDTH-1:0];
`ifdef ADDER_SAT_EN
    if (r > mx) res = WIDTH'(mx);
    else if (r < mn) res = WIDTH'(mn);
`endif
    return {res, o};
  endfunction

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h0000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard and counter model; compares every cycle outside reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      checks++;
      if (bus.ovf_cnt !== CNT_W'(model_cnt)) begin
        errors++;
        $display("FAIL ovf_cnt_model: got %0d expected %0d", bus.ovf_cnt, model_cnt);
      end
      if (bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_output: got %h/%b expected no valid result",
                   bus.adder_out, bus.ovf);
        end else if ({bus.adder_out, bus.ovf} !== exp_q[0]) begin
          errors++;
          $display("FAIL scoreboard: got %h/%b expected %h/%b", bus.adder_out, bus.ovf,
                   exp_q[0][WIDTH:1], exp_q[0][0]);
        end
      end
      if (bus.cnt_clr) model_cnt = 0;
      else if (bus.out_valid && bus.out_ready && exp_q.size() > 0 && exp_q[0][0] &&
               model_cnt < CntMax) model_cnt++;
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_calc(bus.in_0, bus.in_1, bus.sub));
    end
  end

  task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s);
    bit acc;
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_0     = a;
    bus.in_1     = b;
    bus.sub      = s;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      ok = acc;
    end
    if (!ok) drv_stuck++;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(output bit ok);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    ok = (exp_q.size() == 0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_0      = '0;
    bus.in_1      = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    bus.cnt_clr   = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.adder_out !== '0) begin errors++; $display("FAIL reset_adder_out: got %h expected 0", bus.adder_out); end
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
    if (bus.ovf_cnt !== '0) begin errors++; $display("FAIL reset_ovf_cnt: got %0d expected 0", bus.ovf_cnt); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    vec_t             v[6];
    logic [WIDTH-1:0] exp_res;
    int               lat;
    bit               ok;
    v[0] = '{32'h0000_0005, 32'hFFFF_FFFD, 1'b0, 32'h0000_0002, 32'h0000_0002, 1'b0};
    v[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
    v[2] = '{32'h0000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
    v[3] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0};
    v[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
    v[5] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    bus.out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      drain(ok);
`ifdef ADDER_SAT_EN
      exp_res = v[n].sat;
`else
      exp_res = v[n].wrap;
`endif
      bus.in_valid = 1'b1;
      bus.in_0     = v[n].a;
      bus.in_1     = v[n].b;
      bus.sub      = v[n].s;
      lat = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat++;
        if (bus.out_valid) break;
      end
      checks += 3;
      if (lat != STAGES) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", n, lat, STAGES); end
      if (bus.adder_out !== exp_res) begin errors++; $display("FAIL dir%0d_adder_out: got %h expected %h", n, bus.adder_out, exp_res); end
      if (bus.ovf !== v[n].ovf) begin errors++; $display("FAIL dir%0d_ovf: got %b expected %b", n, bus.ovf, v[n].ovf); end
    end
    drain(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL dir_drain: got %0d pending expected 0", exp_q.size()); end
    if (bus.ovf_cnt !== CNT_W'(3)) begin errors++; $display("FAIL dir_ovf_cnt: got %0d expected 3", bus.ovf_cnt); end
  endtask

  task automatic test_random();
    bit done;
    bit ok;
    int n0;
    done = 1'b0;
    n0   = n_out;
    drv_stuck = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          drive_op(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain(ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL rand_drain: got %0d pending expected 0", exp_q.size()); end
    if (n_out - n0 != 150) begin errors++; $display("FAIL rand_count: got %0d results expected 150", n_out - n0); end
    if (drv_stuck != 0) begin errors++; $display("FAIL rand_accept: got %0d stuck ops expected 0", drv_stuck); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n0;
    n0 = n_out;
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) drive_op($urandom, $urandom, 1'(i % 2));
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks += 2;
          if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b expected 0", k, bus.in_ready); end
          if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid%0d: got %b expected 1", k, bus.out_valid); end
          @(posedge clk);
        end
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL bp_drain: got %0d pending expected 0", exp_q.size()); end
    if (n_out - n0 != 8) begin errors++; $display("FAIL bp_count: got %0d results expected 8", n_out - n0); end
  endtask

  task automatic test_counter();
    bit ok;
    for (int i = 0; i < 20; i++) drive_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    drain(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL cnt_drain: got %0d pending expected 0", exp_q.size()); end
    if (bus.ovf_cnt !== CNT_W'(CntMax)) begin errors++; $display("FAIL cnt_saturate: got %0d expected %0d", bus.ovf_cnt, CntMax); end
    bus.out_ready = 1'b0;
    drive_op(32'h8000_0000, 32'h0000_0001, 1'b1);
    for (int k = 0; k < 10 && !bus.out_valid; k++) begin @(posedge clk); #1; end
    checks += 2;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL cnt_held_valid: got %b expected 1", bus.out_valid); end
    if (bus.ovf !== 1'b1) begin errors++; $display("FAIL cnt_held_ovf: got %b expected 1", bus.ovf); end
    bus.cnt_clr   = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.cnt_clr = 1'b0;
    checks += 2;
    if (bus.ovf_cnt !== '0) begin errors++; $display("FAIL cnt_clr_wins: got %0d expected 0", bus.ovf_cnt); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL cnt_clr_consumed: got %b expected 0", bus.out_valid); end
    drive_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    drain(ok);
    checks++;
    if (bus.ovf_cnt !== CNT_W'(1)) begin errors++; $display("FAIL cnt_resume: got %0d expected 1", bus.ovf_cnt); end
  endtask

  task automatic test_reset_midflight();
    logic [WIDTH:0] exp;
    int             lat;
    int             n0;
    bit             ok;
    bus.out_ready = 1'b1;
    drive_op(32'h0000_0001, 32'h0000_0002, 1'b0);
    drive_op(32'h0000_0003, 32'h0000_0004, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_in_flight: got %b expected 1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.ovf_cnt !== '0) begin errors++; $display("FAIL mid_ovf_cnt: got %0d expected 0", bus.ovf_cnt); end
    if (bus.adder_out !== '0) begin errors++; $display("FAIL mid_adder_out: got %h expected 0", bus.adder_out); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = n_out;
    @(posedge clk);
    #1;
    exp = ref_calc(32'h0000_0010, 32'h0000_0020, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_0     = 32'h0000_0010;
    bus.in_1     = 32'h0000_0020;
    bus.sub      = 1'b0;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat++;
      if (bus.out_valid) break;
    end
    checks += 2;
    if (lat != STAGES) begin errors++; $display("FAIL mid_latency: got %0d expected %0d", lat, STAGES); end
    if ({bus.adder_out, bus.ovf} !== exp) begin errors++; $display("FAIL mid_first_result: got %h/%b expected %h/%b", bus.adder_out, bus.ovf, exp[WIDTH:1], exp[0]); end
    drain(ok);
    checks++;
    if (n_out - n0 != 1) begin errors++; $display("FAIL mid_no_stale: got %0d results expected 1", n_out - n0); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_counter();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_signed_adder.md
Name: pipelined_signed_adder

Overview:
Parametrised, pipelined successor to the single-cycle 32-bit signed adder. It performs signed add or subtract on WIDTH-bit operands, flags signed overflow per result and keeps a saturating overflow-event counter. A valid/ready handshake with back-pressure on both sides lets it sit between AXI-stream-style producers and consumers in the PL datapath.

Parameters:
WIDTH, 32, operand/result width in bits; even, >= 4
STAGES, 2, pipeline latency in cycles; legal 1..4
CNT_W, 16, width of overflow event counter

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input operands valid
in_ready  out  1  block can accept operands this cycle
in_0  in  WIDTH  signed operand A
in_1  in  WIDTH  signed operand B
sub  in  1  0: A+B, 1: A-B; sampled with operands
out_valid  out  1  adder_out/ovf valid
out_ready  in  1  downstream accepts result
adder_out  out  WIDTH  signed result
ovf  out  1  signed overflow occurred for this result
cnt_clr  in  1  synchronous clear of ovf_cnt
ovf_cnt  out  CNT_W  number of accepted results with ovf=1, saturating

Behaviour:
- Reset (rst_n=0, async): all stage valid bits 0, out_valid=0, adder_out=0, ovf=0, ovf_cnt=0; in_ready=1 once reset deasserts.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Global stall: adv = !out_valid | out_ready; in_ready = adv. All stage registers load only when adv=1; bubbles propagate as valid=0.
- Latency: result of an accepted operand appears at out_valid exactly STAGES cycles later, if no stall. Throughput 1/cycle with out_ready held high.
- Arithmetic: B' = sub ? ~in_1 : in_1, carry-in = sub; result = in_0 + B' + cin, modulo 2^WIDTH.
- STAGES=1: full add in one stage. STAGES>=2: stage 1 adds lower WIDTH/2 bits, registers partial sum, carry, upper operand halves; stage 2 adds upper half with registered carry. Stages 3..4 are plain delay registers.
- ovf: add: sign(A)==sign(B) and sign(R)!=sign(A). sub: sign(A)!=sign(B) and sign(R)!=sign(A). Covers B = most-negative for sub (e.g. 0 - 0x8000_0000 -> ovf=1).
- adder_out, ovf held stable while out_valid=1 and out_ready=0.
- ovf_cnt increments by 1 on each output transfer with ovf=1; holds at 2^CNT_W-1. cnt_clr=1 sets 0 next cycle; cnt_clr wins over simultaneous increment (that event is dropped).
- in_valid=0 while in_ready=1: bubble enters; no output generated.
- Reset mid-operation: all in-flight results discarded, no partial output.
- Inputs sampled only on input transfer; changes to in_0/in_1/sub while in_ready=0 have no effect.

Optional Feature:
Macro ADDER_SAT_EN. Defined: on ovf=1, adder_out saturates to max positive (0x7FFF_FFFF for WIDTH=32) if sign(A)=0, else most negative (0x8000_0000); ovf still reported and counted. Saturation mux is in the final arithmetic stage; latency unchanged. Undefined: two's-complement wrap, no saturation logic.

Decomposition:
- Package adder_pkg: op encoding constants OP_ADD=0 / OP_SUB=1; functions sat_max(WIDTH) and sat_min(WIDTH); ovf detect function.
- Sub-module pipe_stage: WIDTH-generic payload register plus valid bit, enable=adv, async active-low reset; instantiated for every stage and delay register.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1: 0x0000_0005 + 0xFFFF_FFFD -> adder_out 0x0000_0002, ovf=0, out_valid exactly 2 cycles after input transfer.
- 0x7FFF_FFFF + 0x0000_0001 -> wrap build 0x8000_0000 ovf=1; ADDER_SAT_EN build 0x7FFF_FFFF ovf=1; ovf_cnt=1.
- sub=1: 0x0000_0000 - 0x8000_0000 -> ovf=1; wrap 0x8000_0000, sat 0x7FFF_FFFF. Lower-half carry check: 0x0000_FFFF + 0x0000_0001 -> 0x0001_0000.
- Back-pressure: 8 back-to-back inputs, out_ready low 3 cycles mid-stream -> in_ready drops within same cycle, all 8 results in order, none lost or duplicated, outputs stable during stall.
- Counter: CNT_W=4, 20 overflowing ops -> ovf_cnt holds 0xF; cnt_clr together with an overflowing output transfer -> ovf_cnt=0.
- Assert rst_n low with 2 results in flight -> out_valid=0, ovf_cnt=0 immediately; after release first new input gives first output, no stale data.
